// File: rtl/operand_fetch_stage_if.sv
// Handshake bundles for operand_fetch_stage.
//
// ofs_dec_if : decoder -> operand fetch stage.
//   dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_writes_rd,
//   dec_use_imm and dec_imm are driven by the decoder (master).
//   dec_ready is driven by the stage (slave).
//
// ofs_ex_if : operand fetch stage -> arithmetic unit.
//   ex_valid, ex_opcode, ex_operand_1, ex_operand_2, ex_rd and ex_writes_rd
//   are driven by the stage (master). ex_ready is driven by the arithmetic
//   unit (slave).

interface ofs_dec_if #(
  parameter int WORD_SIZE = 19,
  parameter int OPCODE_W  = 5,
  parameter int REG_AW    = 4
);
  logic                 dec_valid;
  logic                 dec_ready;
  logic [OPCODE_W-1:0]  dec_opcode;
  logic [REG_AW-1:0]    dec_rd;
  logic [REG_AW-1:0]    dec_rs1;
  logic [REG_AW-1:0]    dec_rs2;
  logic                 dec_writes_rd;
  logic                 dec_use_imm;
  logic [WORD_SIZE-1:0] dec_imm;

  modport master (
    output dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2,
           dec_writes_rd, dec_use_imm, dec_imm,
    input  dec_ready
  );

  modport slave (
    input  dec_valid, dec_opcode, dec_rd, dec_rs1, dec_rs2,
           dec_writes_rd, dec_use_imm, dec_imm,
    output dec_ready
  );
endinterface

interface ofs_ex_if #(
  parameter int WORD_SIZE = 19,
  parameter int OPCODE_W  = 5,
  parameter int REG_AW    = 4
);
  logic                 ex_valid;
  logic                 ex_ready;
  logic [OPCODE_W-1:0]  ex_opcode;
  logic [WORD_SIZE-1:0] ex_operand_1;
  logic [WORD_SIZE-1:0] ex_operand_2;
  logic [REG_AW-1:0]    ex_rd;
  logic                 ex_writes_rd;

  modport master (
    output ex_valid, ex_opcode, ex_operand_1, ex_operand_2, ex_rd, ex_writes_rd,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_operand_1, ex_operand_2, ex_rd, ex_writes_rd,
    output ex_ready
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch / issue stage in front of the arithmetic unit.
//
// Accepts decoded instructions, reads the register file, bypasses same-cycle
// writeback data, and blocks RAW/WAW hazards with a per-register scoreboard.
// The issued instruction sits in a one-entry output register (EMPTY/FULL)
// with a valid/ready handshake towards the arithmetic unit.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 kill the issued instruction, clear the scoreboard
//   dec  (ofs_dec_if)     decoded instruction handshake (slave side)
//   rf_raddr1/2           register-file read addresses (= dec_rs1/dec_rs2)
//   rf_rdata1/2           combinational register-file read data
//   wb_valid/wb_rd/wb_data writeback port (bypass + scoreboard clear)
//   ex   (ofs_ex_if)      issued instruction handshake (master side)
//   stall_cnt             saturating count of hazard-stall cycles

module operand_fetch_stage #(
  parameter int WORD_SIZE   = 19,
  parameter int OPCODE_W    = 5,
  parameter int NUM_REGS    = 16,
  parameter int REG_AW      = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  ofs_dec_if.slave               dec,
  output logic [REG_AW-1:0]      rf_raddr1,
  output logic [REG_AW-1:0]      rf_raddr2,
  input  logic [WORD_SIZE-1:0]   rf_rdata1,
  input  logic [WORD_SIZE-1:0]   rf_rdata2,
  input  logic                   wb_valid,
  input  logic [REG_AW-1:0]      wb_rd,
  input  logic [WORD_SIZE-1:0]   wb_data,
  ofs_ex_if.master               ex,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                 state_q;
  logic [OPCODE_W-1:0]    opcode_q;
  logic [WORD_SIZE-1:0]   operand_1_q, operand_2_q;
  logic [REG_AW-1:0]      rd_q;
  logic                   writes_rd_q;
  logic [NUM_REGS-1:0]    sb_q, sb_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic [NUM_REGS-1:0]    wb_mask, busy;
  logic [WORD_SIZE-1:0]   src1, src2;
  logic                   hazard, slot_free, issue;

  assign rf_raddr1 = dec.dec_rs1;
  assign rf_raddr2 = dec.dec_rs2;

  // Operand select: r0 is hard zero, then writeback bypass, then RF data.
  assign src1 = (dec.dec_rs1 == '0)                 ? '0 :
                (wb_valid && wb_rd == dec.dec_rs1)  ? wb_data : rf_rdata1;
  assign src2 = dec.dec_use_imm                     ? dec.dec_imm :
                (dec.dec_rs2 == '0)                 ? '0 :
                (wb_valid && wb_rd == dec.dec_rs2)  ? wb_data : rf_rdata2;

  // A register whose result arrives on the writeback port this cycle is no
  // longer busy, since the bypass delivers the value.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_rd] = 1'b1;
    busy    = sb_q & ~wb_mask;
    busy[0] = 1'b0;
  end

  assign hazard = busy[dec.dec_rs1]
                | (!dec.dec_use_imm && busy[dec.dec_rs2])
                | (dec.dec_writes_rd && busy[dec.dec_rd]);

  assign slot_free     = (state_q == EMPTY) || ex.ex_ready;
  assign dec.dec_ready = rst_n && !flush && slot_free && !hazard;
  assign issue         = dec.dec_valid && dec.dec_ready;

  // Scoreboard next state: the issue-set is applied after the writeback
  // clear so that a same-register collision leaves the bit set.
  always_comb begin
    sb_d = sb_q;
    if (flush) begin
      sb_d = '0;
    end else begin
      if (wb_valid) sb_d[wb_rd] = 1'b0;
      if (issue && dec.dec_writes_rd && dec.dec_rd != '0) sb_d[dec.dec_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Only true hazard stalls are counted; backpressure and flush are not.
  always_comb begin
    stall_d = stall_q;
    if (dec.dec_valid && hazard && slot_free && !flush && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the scoreboard is a small flop vector, not a RAM, so it is reset
  // with everything else; no stale busy bit may survive a reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      opcode_q    <= '0;
      operand_1_q <= '0;
      operand_2_q <= '0;
      rd_q        <= '0;
      writes_rd_q <= 1'b0;
      sb_q        <= '0;
      stall_q     <= '0;
    end else begin
      sb_q    <= sb_d;
      stall_q <= stall_d;

      // issue is impossible during flush, so loading here never conflicts.
      if (issue) begin
        opcode_q    <= dec.dec_opcode;
        operand_1_q <= src1;
        operand_2_q <= src2;
        rd_q        <= dec.dec_rd;
        writes_rd_q <= dec.dec_writes_rd;
      end

      case (state_q)
        EMPTY: if (issue) state_q <= FULL;
        FULL: begin
          if (flush)                       state_q <= EMPTY;
          else if (ex.ex_ready && !issue)  state_q <= EMPTY;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign ex.ex_valid     = (state_q == FULL);
  assign ex.ex_opcode    = opcode_q;
  assign ex.ex_operand_1 = operand_1_q;
  assign ex.ex_operand_2 = operand_2_q;
  assign ex.ex_rd        = rd_q;
  assign ex.ex_writes_rd = writes_rd_q;
  assign stall_cnt       = stall_q;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Issue stage directly upstream of the arithmetic unit. Accepts decoded instructions, reads the register file, and resolves RAW/WAW hazards with a per-register scoreboard. Presents a registered opcode, operand_1 and operand_2 to the arithmetic unit over a valid/ready handshake.
- Writeback results are bypassed into operand selection and clear scoreboard entries.

Parameters:
- WORD_SIZE, 19, datapath width of operands and results
- OPCODE_W, 5, opcode width
- NUM_REGS, 16, architectural registers; r0 reads as zero
- REG_AW, 4, register address width, equal to log2(NUM_REGS)
- STALL_CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  kill the issued instruction and clear the scoreboard
- dec_valid  in  1  decoded instruction valid
- dec_ready  out  1  stage accepts the decoded instruction this cycle
- dec_opcode  in  OPCODE_W  operation code
- dec_rd, dec_rs1, dec_rs2  in  REG_AW each  destination and source registers
- dec_writes_rd  in  1  instruction writes dec_rd
- dec_use_imm  in  1  operand_2 is taken from dec_imm instead of rs2
- dec_imm  in  WORD_SIZE  immediate value
- rf_raddr1, rf_raddr2  out  REG_AW  register-file read addresses (combinational, equal to dec_rs1/dec_rs2)
- rf_rdata1, rf_rdata2  in  WORD_SIZE  combinational read data
- wb_valid  in  1  writeback this cycle
- wb_rd  in  REG_AW  writeback destination
- wb_data  in  WORD_SIZE  writeback value
- ex_valid  out  1  issued instruction valid
- ex_ready  in  1  arithmetic unit consumes the instruction
- ex_opcode  out  OPCODE_W  registered opcode
- ex_operand_1, ex_operand_2  out  WORD_SIZE  registered operands
- ex_rd  out  REG_AW  registered destination
- ex_writes_rd  out  1  registered write enable
- stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst_n=0 at a clock edge): ex_valid=0; ex_opcode, operands, ex_rd, ex_writes_rd all 0; scoreboard all clear; stall_cnt=0. dec_ready is combinational and is 0 while rst_n=0.
- Operand select, src1: r0 gives 0. Otherwise, if wb_valid and wb_rd==rs1, use wb_data (bypass). Otherwise use rf_rdata1.
- Operand select, src2: dec_use_imm gives dec_imm. Otherwise the same rules as src1, applied to rs2.
- Busy(r): scoreboard[r] is set and NOT (wb_valid and wb_rd==r). r0 is never busy.
- Hazard: busy(rs1); OR (!dec_use_imm and busy(rs2)); OR (dec_writes_rd and busy(rd)).
- Slot free: !ex_valid or ex_ready.
- dec_ready = rst_n and !flush and slot_free and !hazard.
- Issue (dec_valid and dec_ready): output registers load next cycle and ex_valid=1. Latency is 1 cycle from acceptance to ex_valid.
- If ex_ready is high with no issue, ex_valid clears. If the slot is not free, the output registers hold stable (no change while ex_valid and !ex_ready).
- Scoreboard update, per register, in priority order:
  - flush: clear all.
  - issue with dec_writes_rd and rd!=0: set scoreboard[rd].
  - wb_valid: clear scoreboard[wb_rd].
  - When issue-set and wb-clear target the same register in one cycle, set wins.
- Flush: next cycle ex_valid=0 and scoreboard=0. No instruction is accepted in the flush cycle. Flush overrides ex_ready and issue.
- stall_cnt increments when dec_valid and hazard and slot_free and !flush, and saturates at all-ones. Backpressure cycles (slot not free) are not counted.
- The stage has two states, EMPTY (ex_valid=0) and FULL (ex_valid=1):
  - EMPTY to FULL on issue.
  - FULL to FULL on ex_ready with issue, or on !ex_ready (hold).
  - FULL to EMPTY on ex_ready without issue, or on flush.
- Reset mid-operation drops the in-flight instruction and all scoreboard state. No partial state survives.
- wb_rd==0 writebacks are ignored for bypass; they still clear nothing meaningful, since r0 is never set.

Test Plan:
- Reset, then dec_valid with opcode=5'd1, rs1=3, rs2=4, rd=5, rf data 19'h00010/19'h00020, ex_ready=1 -> next cycle ex_valid=1, ex_operand_1=19'h00010, ex_operand_2=19'h00020, ex_opcode=1, scoreboard[5]=1.
- RAW: issue rd=5, then rs1=5 with no writeback -> dec_ready=0, stall_cnt increments each cycle; wb_valid with wb_rd=5 and wb_data=19'h7FFFF -> same cycle dec_ready=1, ex_operand_1=19'h7FFFF.
- Backpressure: ex_ready=0 for 3 cycles with a new dec_valid -> ex outputs hold unchanged, dec_ready=0, stall_cnt unchanged; ex_ready=1 -> the next instruction issues back-to-back.
- Same-cycle collision: issue rd=7 while wb_valid with wb_rd=7 -> scoreboard[7]=1 afterwards. r0 sources with rf_rdata=19'h12345 -> operand is 0.
- Immediate: dec_use_imm=1, dec_imm=19'h40000, rs2 busy -> no stall, ex_operand_2=19'h40000.
- Flush with ex_valid=1 and scoreboard bits 2/5 set -> next cycle ex_valid=0, scoreboard=0, dec_ready=0 during the flush cycle. Drive rst_n=0 mid-stall -> all outputs 0 and stall_cnt=0 at the edge.
